// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor controller and its BTB.
package bp_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int TAG_W       = 26;

  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  typedef enum logic [1:0] {
    PCSEL_SEQ     = 2'b00,
    PCSEL_PRED    = 2'b01,
    PCSEL_TAKEN   = 2'b10,
    PCSEL_RECOVER = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11)
      res = cnt + 2'd1;
    else if (!up && cnt != 2'b00)
      res = cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/decode/redirect signal bundle between the pipeline and the branch predictor.
interface branch_predict_ctrl_if;
  logic [31:0] f_pc;
  logic        f_hit;
  logic        f_pred;
  logic [31:0] f_target;
  logic        d_valid;
  logic        d_is_beq;
  logic        d_eq;
  logic [31:0] d_pc;
  logic [31:0] d_target;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        flush_s1;
  logic [31:0] recover_pc;
  logic [15:0] perf_mispred;

  modport master (
    output f_pc, d_valid, d_is_beq, d_eq, d_pc, d_target, stall,
    input  f_hit, f_pred, f_target, pc_sel, flush_s1, recover_pc, perf_mispred
  );

  modport slave (
    input  f_pc, d_valid, d_is_beq, d_eq, d_pc, d_target, stall,
    output f_hit, f_pred, f_target, pc_sel, flush_s1, recover_pc, perf_mispred
  );
endinterface

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: one combinational read port, one clocked write port,
// synchronous clear that takes priority over any write.
module bp_table
  import bp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_cnt,
  output logic [31:0]      rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [1:0]       wr_cnt,
  input  logic [31:0]      wr_target
);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [1:0]             cnt_q    [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];
  assign rd_target = target_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        cnt_q[i]    <= CNT_RESET;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      cnt_q[wr_idx]    <= wr_cnt;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: BTB lookup in fetch, beq resolution in decode,
// PC redirect/flush generation, counter training and mispredict counting.
module branch_predict_ctrl
  import bp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_ctrl_if.slave   bus
);

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_cnt;
  logic [31:0]      rd_target;
  logic             f_hit;
  logic             f_pred;

  logic             hd_q, pd_q;
  logic [1:0]       cd_q;
  state_e           state_q, state_d;
  pc_sel_e          pc_sel;
  logic             flush;
  logic             resolve;
  logic             wr_en;
  logic [1:0]       wr_cnt;
  logic [15:0]      perf_q;
  logic             unused_pc_lsb;

  bp_table u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.f_pc[5:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_cnt    (rd_cnt),
    .rd_target (rd_target),
    .wr_en     (wr_en),
    .wr_idx    (bus.d_pc[5:2]),
    .wr_tag    (bus.d_pc[31:6]),
    .wr_cnt    (wr_cnt),
    .wr_target (bus.d_target)
  );

  assign f_hit  = rd_valid && (rd_tag == bus.f_pc[31:6]);
  assign f_pred = f_hit & rd_cnt[1];

  assign resolve = bus.d_valid & bus.d_is_beq & ~bus.stall & (state_q == ST_RUN) & ~rst;

  always_comb begin
    pc_sel = PCSEL_SEQ;
    if (rst)
      pc_sel = PCSEL_SEQ;
    else if (resolve && pd_q && !bus.d_eq)
      pc_sel = PCSEL_RECOVER;
    else if (resolve && !pd_q && bus.d_eq)
      pc_sel = PCSEL_TAKEN;
    else if (f_pred)
      pc_sel = PCSEL_PRED;
  end

  assign flush = pc_sel[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (flush) state_d = ST_RECOVER;
      ST_RECOVER: if (!bus.stall) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // The counter is trained from the value captured at fetch time alongside Hd/Pd,
  // so the table needs only its single read port.
  always_comb begin
    wr_en  = resolve & (hd_q | bus.d_eq);
    wr_cnt = hd_q ? cnt_step(cd_q, bus.d_eq) : CNT_ALLOC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      hd_q    <= 1'b0;
      pd_q    <= 1'b0;
      cd_q    <= CNT_RESET;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        hd_q <= 1'b0;
        pd_q <= 1'b0;
        cd_q <= CNT_RESET;
      end else if (!bus.stall) begin
        hd_q <= f_hit;
        pd_q <= f_pred;
        cd_q <= rd_cnt;
      end
      if (flush && perf_q != 16'hFFFF)
        perf_q <= perf_q + 16'd1;
    end
  end

  assign unused_pc_lsb = ^{bus.f_pc[1:0], bus.d_pc[1:0]};

  assign bus.f_hit        = f_hit;
  assign bus.f_pred       = f_pred;
  assign bus.f_target     = rd_target;
  assign bus.pc_sel       = pc_sel;
  assign bus.flush_s1     = flush;
  assign bus.recover_pc   = bus.d_pc + 32'd4;
  assign bus.perf_mispred = perf_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: a vector table for single-cycle redirect
// decisions plus hand-written sequences for training, stall deferral, aliasing and reset.
module tb_branch_predict_ctrl;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  branch_predict_ctrl_if bus ();

  branch_predict_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        d_valid;
    logic        d_is_beq;
    logic        d_eq;
    logic        stall;
    logic [31:0] d_pc;
    logic [1:0]  exp_sel;
    logic        exp_flush;
    logic [31:0] exp_rec;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] fpc, input logic dv, input logic beq,
                       input logic eq, input logic [31:0] dpc, input logic [31:0] dtgt,
                       input logic stl);
    bus.f_pc     = fpc;
    bus.d_valid  = dv;
    bus.d_is_beq = beq;
    bus.d_eq     = eq;
    bus.d_pc     = dpc;
    bus.d_target = dtgt;
    bus.stall    = stl;
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(32'h0);
    step();
    rst = 1'b0;
  endtask

  // Fetch pc, then resolve it in decode; checks the redirect and finishes any recovery cycle.
  task automatic beq_pair(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic eq, input logic [1:0] exp_sel, input logic exp_flush);
    idle(pc);
    step();
    drive(32'h200, 1'b1, 1'b1, eq, pc, tgt, 1'b0);
    check({name, ".sel"}, 32'(bus.pc_sel), 32'(exp_sel));
    check({name, ".flush"}, 32'(bus.flush_s1), 32'(exp_flush));
    step();
    idle(32'h200);
    if (exp_flush) step();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 2'b10, 1'b1, 32'h0000_0044};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 2'b00, 1'b0, 32'h0000_0084};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 2'b00, 1'b0, 32'h0000_1004};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 2'b00, 1'b0, 32'h0000_0044};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 2'b00, 1'b0, 32'h0000_0044};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 2'b00, 1'b0, 32'h0000_0044};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 2'b10, 1'b1, 32'h0000_0000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0000_0014};

    do_reset();
    check("reset.perf", 32'(bus.perf_mispred), 32'h0);
    check("reset.hit", 32'(bus.f_hit), 32'h0);
    check("reset.state", 32'(dut.state_q), 32'(ST_RUN));

    // Single-cycle redirect decisions from a clean, empty predictor
    for (int i = 0; i < 8; i++) begin
      do_reset();
      rst = vecs[i].rst;
      drive(32'h40, vecs[i].d_valid, vecs[i].d_is_beq, vecs[i].d_eq, vecs[i].d_pc,
            32'h100, vecs[i].stall);
      check($sformatf("vec%0d.sel", i), 32'(bus.pc_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d.flush", i), 32'(bus.flush_s1), 32'(vecs[i].exp_flush));
      check($sformatf("vec%0d.rec", i), bus.recover_pc, vecs[i].exp_rec);
      rst = 1'b0;
    end

    // Cold taken beq allocates entry 0
    do_reset();
    idle(32'h40);
    check("cold.hit", 32'(bus.f_hit), 32'h0);
    step();
    drive(32'h44, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 1'b0);
    check("cold.sel", 32'(bus.pc_sel), 32'h2);
    check("cold.flush", 32'(bus.flush_s1), 32'h1);
    step();
    check("cold.perf", 32'(bus.perf_mispred), 32'h1);
    check("cold.cnt", 32'(dut.u_table.cnt_q[0]), 32'h2);
    check("cold.state", 32'(dut.state_q), 32'(ST_RECOVER));
    drive(32'h100, 1'b1, 1'b1, 1'b1, 32'h44, 32'h400, 1'b0);
    check("cold.recsel", 32'(bus.pc_sel), 32'h0);
    check("cold.recflush", 32'(bus.flush_s1), 32'h0);
    step();
    check("cold.norecwrite", 32'(dut.u_table.valid_q[1]), 32'h0);

    // Re-fetch hits and trains up to strongly taken
    idle(32'h40);
    check("hot.hit", 32'(bus.f_hit), 32'h1);
    check("hot.pred", 32'(bus.f_pred), 32'h1);
    check("hot.tgt", bus.f_target, 32'h100);
    check("hot.sel", 32'(bus.pc_sel), 32'h1);
    beq_pair("hot1", 32'h40, 32'h100, 1'b1, 2'b00, 1'b0);
    check("hot1.cnt", 32'(dut.u_table.cnt_q[0]), 32'h3);
    beq_pair("hot2", 32'h40, 32'h100, 1'b1, 2'b00, 1'b0);
    check("hot2.cnt", 32'(dut.u_table.cnt_q[0]), 32'h3);
    check("hot2.perf", 32'(bus.perf_mispred), 32'h1);

    // Not-taken resolutions walk the counter down and recover
    beq_pair("down1", 32'h40, 32'h100, 1'b0, 2'b11, 1'b1);
    check("down1.cnt", 32'(dut.u_table.cnt_q[0]), 32'h2);
    idle(32'h40);
    check("down2.pred", 32'(bus.f_pred), 32'h1);
    step();
    drive(32'h200, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0);
    check("down2.sel", 32'(bus.pc_sel), 32'h3);
    check("down2.rec", bus.recover_pc, 32'h44);
    check("down2.flush", 32'(bus.flush_s1), 32'h1);
    step();
    check("down2.cnt", 32'(dut.u_table.cnt_q[0]), 32'h1);
    check("down2.state", 32'(dut.state_q), 32'(ST_RECOVER));
    drive(32'h300, 1'b1, 1'b1, 1'b1, 32'h88, 32'h500, 1'b0);
    check("down2.recsel", 32'(bus.pc_sel), 32'h0);
    step();
    idle(32'h88);
    check("down2.noalloc", 32'(bus.f_hit), 32'h0);
    check("down2.perf", 32'(bus.perf_mispred), 32'h3);

    // Mispredict held off by stall, taken on the first free cycle
    idle(32'h40);
    check("stall.hit", 32'(bus.f_hit), 32'h1);
    check("stall.pred", 32'(bus.f_pred), 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(32'h44, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1);
      check($sformatf("stall%0d.sel", i), 32'(bus.pc_sel), 32'h0);
      check($sformatf("stall%0d.flush", i), 32'(bus.flush_s1), 32'h0);
      step();
    end
    check("stall.cnt", 32'(dut.u_table.cnt_q[0]), 32'h1);
    check("stall.perf", 32'(bus.perf_mispred), 32'h3);
    drive(32'h44, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 1'b0);
    check("unstall.sel", 32'(bus.pc_sel), 32'h2);
    check("unstall.flush", 32'(bus.flush_s1), 32'h1);
    step();
    check("unstall.cnt", 32'(dut.u_table.cnt_q[0]), 32'h2);
    check("unstall.perf", 32'(bus.perf_mispred), 32'h4);
    idle(32'h200);
    step();

    // Alias at the same index replaces the older entry
    beq_pair("alias", 32'h1040, 32'h300, 1'b1, 2'b10, 1'b1);
    idle(32'h40);
    check("alias.oldhit", 32'(bus.f_hit), 32'h0);
    idle(32'h1040);
    check("alias.newhit", 32'(bus.f_hit), 32'h1);
    check("alias.tgt", bus.f_target, 32'h300);
    check("alias.cnt", 32'(dut.u_table.cnt_q[0]), 32'h2);
    check("alias.perf", 32'(bus.perf_mispred), 32'h5);

    // Reset while recovering with a resolve pending
    step();
    drive(32'h200, 1'b1, 1'b1, 1'b0, 32'h1040, 32'h300, 1'b0);
    check("rstrec.sel0", 32'(bus.pc_sel), 32'h3);
    step();
    check("rstrec.state0", 32'(dut.state_q), 32'(ST_RECOVER));
    rst = 1'b1;
    drive(32'h1040, 1'b1, 1'b1, 1'b1, 32'h1040, 32'h500, 1'b0);
    check("rstrec.sel", 32'(bus.pc_sel), 32'h0);
    check("rstrec.flush", 32'(bus.flush_s1), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rstrec.state", 32'(dut.state_q), 32'(ST_RUN));
    check("rstrec.perf", 32'(bus.perf_mispred), 32'h0);
    check("rstrec.hit", 32'(bus.f_hit), 32'h0);
    check("rstrec.cnt", 32'(dut.u_table.cnt_q[0]), 32'(CNT_RESET));
    check("rstrec.tgt", dut.u_table.target_q[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
